an_decoder_barrett_pipe: RTL
============================

# an_decoder_barrett_pipe

Parametrised, pipelined AN-code decoder for arithmetic codes with single-error correction. A codeword is `A·m` plus an optional error of ±2^i. The block:
- computes the residue with Barrett reduction,
- maps a nonzero residue to an error of ±2^i,
- corrects the codeword and recovers `m` with a second Barrett quotient.

It sits between the AN-coded datapath and message consumers. It has a valid/ready stream interface and saturating error-statistics counters.

## Interface
- `A`, 13, odd code constant; syndromes ±2^i mod A (i=0..NW-1) must be distinct and nonzero.
- `NW`, 6, codeword width.
- `K`, 3, message width; must satisfy floor((2^NW−1)/A) < 2^K.
- `RW`, 4, residue width, equal to clog2(A).
- `CW`, 16, statistics counter width.
- `clk` input 1: single clock, all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: input codeword valid.
- `in_ready` output 1: block accepts a codeword this cycle.
- `in_codeword` input NW: received codeword.
- `out_valid` output 1: decoded result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_message` output K: decoded message.
- `out_corrected` output 1: a single ±2^i error was corrected.
- `out_uncorr` output 1: correction is impossible; `out_message` is forced to 0.
- `out_residue` output RW: raw residue of the received codeword mod A.
- `cnt_clr` input 1: synchronous clear of both counters.
- `cnt_corr` output CW: saturating count of corrected results delivered.
- `cnt_uncorr` output CW: saturating count of uncorrectable results delivered.

## Operation

**Barrett constants.** Elaboration-time constants: kb = 2·NW, M = floor(2^kb / A).

**Barrett step for x < 2^NW:**
- q = (x·M) >> kb.
- r = x − q·A.
- If r ≥ A, then r −= A and q += 1.
- One conditional correction is sufficient and is the only one implemented.
- Intermediate x·M is full width, NW + kb bits; no truncation.

**Stage S1.** Register `in_codeword` when accepted.

**Stage S2.** Barrett residue r of the S1 codeword. Register codeword and r.

**Stage S3: syndrome match and correction.**
- If r = 0: e = 0, not corrected.
- Otherwise scan i = 0..NW−1 and take the first match:
  - r = 2^i mod A gives e = +2^i.
  - r = A − (2^i mod A) gives e = −2^i.
  - The positive match is checked before the negative match at the same i.
- Corrected word c = codeword − e, computed signed at NW+2 bits.
- Uncorrectable if r ≠ 0 and no match, or if c < 0, or if c > 2^NW − 1.
- Register c[NW−1:0], corrected flag, uncorrectable flag and r.

**Stage S4.** Barrett quotient q of c.
- Uncorrectable results give message 0.
- Otherwise the message is q[K−1:0]. q < 2^K is guaranteed by the parameter constraint.
- The remainder of c is zero by construction and is not checked.

**Output register.** Holds `out_*` until the handshake completes.

**Statistics counters.**
- On the output handshake (out_valid & out_ready):
  - `cnt_corr` increments if out_corrected.
  - `cnt_uncorr` increments if out_uncorr.
- Both counters saturate at 2^CW − 1.
- `cnt_clr` has priority over an increment in the same cycle; the counter reads 0 next cycle.

## Timing
- **Reset**, rst_n = 0 at a clock edge:
  - all stage valid bits are 0;
  - out_valid = 0, out_message = 0, out_corrected = 0, out_uncorr = 0, out_residue = 0;
  - cnt_corr = 0, cnt_uncorr = 0.
- **Reset mid-operation:** in-flight data is discarded, with no partial output. in_ready is 0 during reset.
- **Pipeline enable:** en = !out_valid | out_ready.
  - in_ready = en & rst_n.
  - All stages advance only when en = 1.
  - Bubbles propagate as valid = 0.
- **Latency:** a codeword accepted at edge t appears with out_valid = 1 after edge t+4 when there is no back-pressure.
- **Throughput:** 1 codeword per cycle.
- **Back-pressure:**
  - With out_valid = 1 and out_ready = 0, all outputs hold stable and in_ready = 0.
  - No data is lost or duplicated.
  - Holding out_ready = 0 for N cycles delays every queued result by exactly N cycles, in order.
- **Counters:** update one edge after the handshake. A held output is counted once.

## Test plan
- **Clean stream, A=13, NW=6, K=3:** codewords 0, 13, 26, 39, 52 back-to-back, out_ready = 1.
  - Messages 0, 1, 2, 3, 4 on 5 consecutive cycles, first valid 4 cycles after the first accept.
  - All flags 0, residues 0, counters unchanged.
- **Single-error correction:**
  - 43 gives residue 4, e = +4: message 3, corrected = 1.
  - 31 gives residue 5, e = −8: message 3, corrected = 1.
  - 1 gives residue 1: message 0, corrected = 1.
  - Expected counter state: cnt_corr = 3.
- **Uncorrectable:** 63 gives residue 11, e = −2, c = 65 > 63.
  - out_uncorr = 1, out_message = 0, out_residue = 11, cnt_uncorr = 1.
- **Back-pressure:** feed 5 codewords, hold out_ready = 0 for 6 cycles, then release.
  - in_ready drops, the first output holds stable, all 5 results arrive in order.
  - Each result is counted once.
- **Counters:** preload near saturation with CW=2.
  - 4 corrected results give cnt_corr = 3, saturated.
  - cnt_clr asserted in the same cycle as a corrected handshake gives cnt_corr = 0.
- **Reset mid-stream:** rst_n = 0 for 1 cycle with 3 items in flight.
  - out_valid = 0 and all outputs 0 next cycle.
  - No stale result emerges afterwards.
  - A new codeword 26 returns message 2 after 4 cycles.

Source files
------------

// File: rtl/an_decoder_barrett_pipe.sv
// AN-code decoder: Barrett residue, single +/-2^i error correction, Barrett quotient recovery.
// Latency: 4 cycles from input accept to out_valid, 1 codeword per cycle throughput.
// Backpressure: whole pipeline stalls while out_valid & !out_ready; in_ready follows the stall.
module an_decoder_barrett_pipe #(
  parameter int A  = 13,
  parameter int NW = 6,
  parameter int K  = 3,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_codeword,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_message,
  output logic          out_corrected,
  output logic          out_uncorr,
  output logic [RW-1:0] out_residue,
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt_corr,
  output logic [CW-1:0] cnt_uncorr
);

  localparam int            KB     = 2 * NW;
  localparam logic [KB:0]   BM     = (KB+1)'((64'd1 << KB) / 64'(A));
  localparam logic [NW-1:0] A_NW   = NW'(A);
  localparam logic [RW-1:0] A_RW   = RW'(A);
  localparam logic [NW-1:0] ONE_NW = NW'(1);

  // Barrett quotient estimate floor(x*M / 2^kb); the product is kept at full width.
  function automatic logic [NW-1:0] barrett_est(input logic [NW-1:0] x);
    logic [NW+KB-1:0] prod;
    prod = {{KB{1'b0}}, x} * {{(NW-1){1'b0}}, BM};
    return NW'(prod >> KB);
  endfunction

  // Residue after the single conditional correction step.
  function automatic logic [RW-1:0] barrett_r(input logic [NW-1:0] x);
    logic [NW-1:0] q;
    logic [NW-1:0] r;
    q = barrett_est(x);
    r = x - q * A_NW;
    if (r >= A_NW) r = r - A_NW;
    return RW'(r);
  endfunction

  // Quotient after the single conditional correction step.
  function automatic logic [K-1:0] barrett_q(input logic [NW-1:0] x);
    logic [NW-1:0] q;
    logic [NW-1:0] r;
    q = barrett_est(x);
    r = x - q * A_NW;
    if (r >= A_NW) q = q + ONE_NW;
    return K'(q);
  endfunction

  // 2^i mod A, folded to a constant once the scan loop unrolls.
  function automatic logic [RW-1:0] pow2mod(input int i);
    return RW'((64'd1 << i) % 64'(A));
  endfunction

  logic          w_en;
  logic          r_v1, r_v2, r_v3, r_v4;
  logic [NW-1:0] r_cw1, r_cw2, r_c3;
  logic [RW-1:0] r_res2, r_res3, r_res4;
  logic          r_corr3, r_unc3, r_corr4, r_unc4;
  logic [K-1:0]  r_msg4;
  logic          w_found;
  logic [NW+1:0] w_e;
  logic [NW+1:0] w_c;
  logic          w_unc;
  logic          w_hs;

  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en & rst_n;
  assign w_hs     = out_valid & out_ready;

  // S1/S2: capture the codeword, then its residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_cw1  <= '0;
      r_v2   <= 1'b0;
      r_cw2  <= '0;
      r_res2 <= '0;
    end else if (w_en) begin
      r_v1   <= in_valid;
      r_cw1  <= in_codeword;
      r_v2   <= r_v1;
      r_cw2  <= r_cw1;
      r_res2 <= barrett_r(r_cw1);
    end
  end

  // Syndrome scan: first i wins, +2^i checked before -2^i; correction done at NW+2 bits signed.
  always_comb begin
    w_found = 1'b0;
    w_e     = '0;
    for (int i = 0; i < NW; i++) begin
      if (!w_found && r_res2 != '0) begin
        if (r_res2 == pow2mod(i)) begin
          w_found = 1'b1;
          w_e     = (NW+2)'(1) << i;
        end else if (r_res2 == A_RW - pow2mod(i)) begin
          w_found = 1'b1;
          w_e     = '0 - ((NW+2)'(1) << i);
        end
      end
    end
    w_c   = {2'b00, r_cw2} - w_e;
    // Sign bit set means c < 0; bit NW set means c > 2^NW - 1.
    w_unc = (r_res2 != '0 && !w_found) || w_c[NW+1] || w_c[NW];
  end

  // S3/S4: register the corrected word, then recover the message from it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_c3    <= '0;
      r_corr3 <= 1'b0;
      r_unc3  <= 1'b0;
      r_res3  <= '0;
      r_v4    <= 1'b0;
      r_msg4  <= '0;
      r_corr4 <= 1'b0;
      r_unc4  <= 1'b0;
      r_res4  <= '0;
    end else if (w_en) begin
      r_v3    <= r_v2;
      r_c3    <= w_c[NW-1:0];
      r_corr3 <= w_found & !w_unc;
      r_unc3  <= w_unc;
      r_res3  <= r_res2;
      r_v4    <= r_v3;
      r_msg4  <= r_unc3 ? '0 : barrett_q(r_c3);
      r_corr4 <= r_corr3;
      r_unc4  <= r_unc3;
      r_res4  <= r_res3;
    end
  end

  // Output register: holds while the consumer stalls; bubbles only clear out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_message   <= '0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
      out_residue   <= '0;
    end else if (w_en) begin
      out_valid <= r_v4;
      if (r_v4) begin
        out_message   <= r_msg4;
        out_corrected <= r_corr4;
        out_uncorr    <= r_unc4;
        out_residue   <= r_res4;
      end
    end
  end

  // Saturating statistics, counted on the handshake edge; clear beats increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (w_hs) begin
      if (out_corrected && cnt_corr != '1) cnt_corr <= cnt_corr + CW'(1);
      if (out_uncorr && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + CW'(1);
    end
  end

endmodule
